// File: rtl/inst_pipeline_regs.sv
// Instruction/PC register chain for the 3-stage core (D -> X -> Mem_WB).
// Covers stall, redirect flush, load-use bubble insertion and the CSR counters.
module inst_pipeline_regs #(
  parameter logic [31:0] NOP_INST       = 32'h0000_0013,
  parameter int          LOAD_USE_STALL = 1,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [31:0]      fetch_inst,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_valid,
  input  logic             redirect,
  input  logic             cnt_clear,
  output logic [31:0]      D_inst,
  output logic [31:0]      X_inst,
  output logic [31:0]      Mem_WB_inst,
  output logic [31:0]      D_pc,
  output logic [31:0]      X_pc,
  output logic [31:0]      Mem_WB_pc,
  output logic             D_valid,
  output logic             X_valid,
  output logic             Mem_WB_valid,
  output logic             load_use_bubble,
  output logic             fetch_hold,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [6:0]       OP_LOAD  = 7'b0000011;
  localparam logic [6:0]       OP_LUI   = 7'b0110111;
  localparam logic [6:0]       OP_AUIPC = 7'b0010111;
  localparam logic [6:0]       OP_JAL   = 7'b1101111;
  localparam logic [6:0]       OP_REG   = 7'b0110011;
  localparam logic [6:0]       OP_STORE = 7'b0100011;
  localparam logic [6:0]       OP_BR    = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      r_d_inst, r_x_inst, r_wb_inst;
  logic [31:0]      r_d_pc, r_x_pc, r_wb_pc;
  logic             r_d_valid, r_x_valid, r_wb_valid;
  logic [CNT_W-1:0] r_cycle_cnt, r_instret_cnt;

  logic [6:0] w_x_op, w_d_op;
  logic [4:0] w_x_rd, w_d_rs1, w_d_rs2;
  logic       w_d_uses_rs1, w_d_uses_rs2, w_hz, w_bubble;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG || op == OP_STORE || op == OP_BR);
  endfunction

  assign w_x_op       = r_x_inst[6:0];
  assign w_x_rd       = r_x_inst[11:7];
  assign w_d_op       = r_d_inst[6:0];
  assign w_d_rs1      = r_d_inst[19:15];
  assign w_d_rs2      = r_d_inst[24:20];
  assign w_d_uses_rs1 = uses_rs1(w_d_op);
  assign w_d_uses_rs2 = uses_rs2(w_d_op);

  // A load in X whose rd feeds a source D actually reads cannot forward in time.
  assign w_hz = (LOAD_USE_STALL != 0) && r_x_valid && r_d_valid &&
                (w_x_op == OP_LOAD) && (w_x_rd != 5'd0) &&
                (((w_x_rd == w_d_rs1) && w_d_uses_rs1) ||
                 ((w_x_rd == w_d_rs2) && w_d_uses_rs2));

  assign w_bubble        = w_hz && !redirect && !stall;
  assign load_use_bubble = w_bubble;
  assign fetch_hold      = stall | w_bubble;

  // ---- stage registers: fetch -> D -> X -> Mem_WB ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_d_inst   <= NOP_INST;
      r_x_inst   <= NOP_INST;
      r_wb_inst  <= NOP_INST;
      r_d_pc     <= '0;
      r_x_pc     <= '0;
      r_wb_pc    <= '0;
      r_d_valid  <= 1'b0;
      r_x_valid  <= 1'b0;
      r_wb_valid <= 1'b0;
    end else if (!stall) begin
      r_wb_inst  <= r_x_inst;
      r_wb_pc    <= r_x_pc;
      r_wb_valid <= r_x_valid;
      if (redirect) begin
        r_x_inst  <= NOP_INST;
        r_x_pc    <= '0;
        r_x_valid <= 1'b0;
        r_d_inst  <= NOP_INST;
        r_d_pc    <= '0;
        r_d_valid <= 1'b0;
      end else if (w_bubble) begin
        r_x_inst  <= NOP_INST;
        r_x_pc    <= '0;
        r_x_valid <= 1'b0;
      end else begin
        r_x_inst  <= r_d_inst;
        r_x_pc    <= r_d_pc;
        r_x_valid <= r_d_valid;
        r_d_inst  <= fetch_valid ? fetch_inst : NOP_INST;
        r_d_pc    <= fetch_pc;
        r_d_valid <= fetch_valid;
      end
    end
  end

  // ---- CSR counters: cycles run through stalls, instret counts Mem_WB retirements ----
  always_ff @(posedge clk) begin
    if (!reset_n || cnt_clear) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
      if (r_wb_valid && !stall) begin
        r_instret_cnt <= r_instret_cnt + CNT_ONE;
      end
    end
  end

  assign D_inst       = r_d_inst;
  assign X_inst       = r_x_inst;
  assign Mem_WB_inst  = r_wb_inst;
  assign D_pc         = r_d_pc;
  assign X_pc         = r_x_pc;
  assign Mem_WB_pc    = r_wb_pc;
  assign D_valid      = r_d_valid;
  assign X_valid      = r_x_valid;
  assign Mem_WB_valid = r_wb_valid;
  assign cycle_cnt    = r_cycle_cnt;
  assign instret_cnt  = r_instret_cnt;

endmodule

// File: doc/inst_pipeline_regs.md
Name: inst_pipeline_regs

Overview:
- Instruction/PC pipeline register chain for the 3-stage core: Decode (D), Execute (X), Mem/Writeback (Mem_WB).
- Sits directly upstream of the forwarding unit and produces the D_inst, X_inst and Mem_WB_inst words it consumes.
- Handles global stall, control-flow redirect flush and optional load-use bubble insertion.
- Owns the cycle and retired-instruction counters read by CSR logic.

Parameters:
- NOP_INST, 32'h0000_0013, canonical bubble (addi x0,x0,0).
- LOAD_USE_STALL, 1, 1 = insert one bubble on load-use hazard; 0 = never bubble.
- CNT_W, 32, width of cycle/instret counters.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  synchronous active-low reset.
- stall  in  1  global stall from I$/D$; freezes all stage registers.
- fetch_inst  in  32  instruction from I$.
- fetch_pc  in  32  PC of fetch_inst.
- fetch_valid  in  1  fetch_inst is valid this cycle.
- redirect  in  1  X-stage taken branch/jump; kills D and the fetch slot.
- cnt_clear  in  1  synchronous clear of both counters.
- D_inst / X_inst / Mem_WB_inst  out  32 each  stage instruction words.
- D_pc / X_pc / Mem_WB_pc  out  32 each  stage PCs.
- D_valid / X_valid / Mem_WB_valid  out  1 each  stage holds a real instruction.
- load_use_bubble  out  1  combinational; bubble inserted this cycle.
- fetch_hold  out  1  combinational; fetch must re-present the same fetch_inst/pc next cycle.
- cycle_cnt  out  CNT_W  cycles since reset/clear.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-low: reset_n sampled low at a rising clk edge resets state. No asynchronous path.
  - Reset values: all *_inst = NOP_INST, all *_pc = 0, all *_valid = 0, both counters = 0.
  - reset_n has priority over every other input.
- Load-use hazard (hz), combinational, only when LOAD_USE_STALL=1. All of the following must hold:
  - X_valid, D_valid, X opcode = 7'b0000011, X_rd != 0.
  - X_rd == D_rs1 and D uses rs1 (opcode not LUI 0110111, AUIPC 0010111 or JAL 1101111), OR X_rd == D_rs2 and D uses rs2 (opcodes 0110011, 0100011, 1100011).
- load_use_bubble = hz & ~redirect & ~stall.
- Per rising edge, when reset_n=1, in priority order:
  1. stall=1: every stage register holds its value.
  2. redirect=1:
     - Mem_WB <= X.
     - X <= {NOP_INST, pc 0, valid 0}.
     - D <= {NOP_INST, pc 0, valid 0}; fetch slot discarded.
     - redirect overrides hz.
  3. load_use_bubble=1:
     - Mem_WB <= X.
     - X <= NOP bubble (valid 0).
     - D holds.
  4. Otherwise:
     - Mem_WB <= X, X <= D.
     - D <= fetch_valid ? {fetch_inst, fetch_pc, 1} : {NOP_INST, fetch_pc, 0}.
- A bubble always carries NOP_INST in the inst field, so downstream decode of an invalid stage is harmless.
- fetch_hold = stall | load_use_bubble.
- Latency: a fetch word accepted at edge N appears on D at N, X at N+1 and Mem_WB at N+2, absent stall or bubble.
- Counters:
  - cycle_cnt increments every cycle, including stall cycles.
  - instret_cnt increments on an edge where Mem_WB_valid=1 and stall=0.
  - Both wrap modulo 2^CNT_W with no saturation.
  - cnt_clear=1 zeroes both counters on that edge and overrides the increment.
- Simultaneous events:
  - stall with redirect: stall wins. redirect must be held by its source until stall drops.
  - Reset mid-stall or mid-bubble: all state returns to reset values on that edge.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with fetch_valid=1 -> all valids 0, insts 32'h00000013, counters 0. Release -> instruction A (pc 0x100) reaches Mem_WB after 3 edges with Mem_WB_pc=0x100.
- Stall: stall=1 for 3 cycles while D=A, X=B, Mem_WB=C -> all held; cycle_cnt +3; instret_cnt unchanged; fetch_hold=1.
- Redirect:
  - Stimulus: X=beq (valid), D=D1, fetch=F1, redirect=1.
  - Required: next cycle Mem_WB=beq; X and D are NOP with valid 0; F1 is never seen in D.
- Load-use:
  - Stimulus: X=lw x5,0(x1); D=add x6,x5,x2.
  - Required: load_use_bubble=1; next cycle X is a NOP bubble and D is still add; the following cycle X=add. Repeat with D=add x6,x0,x2 -> no bubble. Repeat with LOAD_USE_STALL=0 -> no bubble.
- Priority: hazard present with redirect=1 -> load_use_bubble=0 and flush occurs. Hazard present with stall=1 -> load_use_bubble=0 and all stages held.
- Counters:
  - Preload instret_cnt to 32'hFFFF_FFFF via a run, then retire one instruction -> 0.
  - cnt_clear on an edge with Mem_WB_valid=1 -> both counters 0.
